// File: rtl/bus_xfer_pkg.sv
// Shared definitions for the bus-transfer initiator: FSM encoding, settle
// counter width and an index-width helper used by the top and the decoder.
package bus_xfer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_WRITE = 2'd2,
        ST_HOLD  = 2'd3
    } xfer_state_e;

    localparam int SETTLE_CNT_W = 4;

    // Index width for n selectable items; a single item still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/strobe_dec.sv
// Index-to-strobe decoder: drives the selected bit low when enabled,
// otherwise leaves every strobe high.
module strobe_dec
    import bus_xfer_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IDX_W = idx_width(WIDTH)
) (
    input  logic [IDX_W-1:0] i_idx,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_strobe_n
);

    always_comb begin
        o_strobe_n = '1;
        for (int i = 0; i < WIDTH; i++) begin
            if (i_en && (i_idx == IDX_W'(i))) begin
                o_strobe_n[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Bus-transfer initiator: sequences source drive/settle, a one-cycle destination
// write and a one-cycle hold so each move has a single driver and a single capture.
module bus_xfer_ctrl
    import bus_xfer_pkg::*;
#(
    parameter int N_SRC         = 4,
    parameter int N_DST         = 4,
    parameter int SETTLE_CYCLES = 1,
    localparam int SRC_W        = idx_width(N_SRC),
    localparam int DST_W        = idx_width(N_DST)
) (
    input  logic             i_clk,
    input  logic             i_nReset,
    input  logic             i_reqValid,
    output logic             o_reqReady,
    input  logic [SRC_W-1:0] i_reqSrc,
    input  logic [DST_W-1:0] i_reqDst,
    input  logic             i_abort,
    output logic [N_SRC-1:0] o_srcNOE,
    output logic [N_DST-1:0] o_dstNWE,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err
);

    xfer_state_e             state_q, state_d;
    logic [SETTLE_CNT_W-1:0] cnt_q, cnt_d;
    logic [SRC_W-1:0]        src_q, src_d;
    logic [DST_W-1:0]        dst_q, dst_d;
    logic [N_SRC-1:0]        noe_q, noe_d;
    logic [N_DST-1:0]        nwe_q, nwe_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic                    ready_q, ready_d;
    logic                    busy_q, busy_d;
    logic                    src_en, dst_en;
    logic                    req_bad;

    assign req_bad = ({1'b0, i_reqSrc} >= (SRC_W + 1)'(N_SRC)) ||
                     ({1'b0, i_reqDst} >= (DST_W + 1)'(N_DST));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        dst_d   = dst_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_reqValid && ready_q) begin
                    if (req_bad) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ST_DRIVE;
                        src_d   = i_reqSrc;
                        dst_d   = i_reqDst;
                        cnt_d   = SETTLE_CNT_W'(SETTLE_CYCLES - 1);
                    end
                end
            end
            ST_DRIVE: begin
                if (i_abort) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ST_WRITE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_WRITE: begin
                state_d = ST_HOLD;
                done_d  = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Strobes are decoded from the next state so they are registered with it.
        src_en  = (state_d != ST_IDLE);
        dst_en  = (state_d == ST_WRITE);
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
    end

    strobe_dec #(.WIDTH(N_SRC), .IDX_W(SRC_W)) u_src_dec (
        .i_idx      (src_d),
        .i_en       (src_en),
        .o_strobe_n (noe_d)
    );

    strobe_dec #(.WIDTH(N_DST), .IDX_W(DST_W)) u_dst_dec (
        .i_idx      (dst_d),
        .i_en       (dst_en),
        .o_strobe_n (nwe_d)
    );

    always_ff @(posedge i_clk) begin
        if (!i_nReset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            noe_q   <= '1;
            nwe_q   <= '1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            noe_q   <= noe_d;
            nwe_q   <= nwe_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign o_srcNOE   = noe_q;
    assign o_dstNWE   = nwe_q;
    assign o_done     = done_q;
    assign o_err      = err_q;
    assign o_reqReady = ready_q;
    assign o_busy     = busy_q;

endmodule
